// File: rtl/demux_route_pkg.sv
// demux_route_pkg: shared FSM encoding and destination-to-select mapping
// for the demux routing controller.
package demux_route_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] DEST_Y0 = 2'd0;
    localparam logic [1:0] DEST_Y1 = 2'd1;
    localparam logic [1:0] DEST_Y2 = 2'd2;
    localparam logic [1:0] DEST_Y3 = 2'd3;

    // s0 picks the branch: 0 = y0/y1, 1 = y2/y3
    localparam logic S0_LOW_BRANCH  = 1'b0;
    localparam logic S0_HIGH_BRANCH = 1'b1;

    // Leaf select inside a branch: 0 = even output, 1 = odd output
    localparam logic LEAF_EVEN = 1'b0;
    localparam logic LEAF_ODD  = 1'b1;

endpackage

// File: rtl/route_sel_decode.sv
// route_sel_decode: dest index -> hierarchical demux selects + one-hot mask.
// Ports: dest, s1_prev/s2_prev (held values) -> s0, s1, s2, mask.
module route_sel_decode
    import demux_route_pkg::*;
(
    input  logic [1:0] dest,
    input  logic       s1_prev,
    input  logic       s2_prev,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [3:0] mask
);

    always_comb begin
        s0   = S0_LOW_BRANCH;
        s1   = s1_prev;
        s2   = s2_prev;
        mask = 4'b0000;
        unique case (dest)
            DEST_Y0: begin
                s0   = S0_LOW_BRANCH;
                s1   = LEAF_EVEN;
                mask = 4'b0001;
            end
            DEST_Y1: begin
                s0   = S0_LOW_BRANCH;
                s1   = LEAF_ODD;
                mask = 4'b0010;
            end
            DEST_Y2: begin
                s0   = S0_HIGH_BRANCH;
                s2   = LEAF_EVEN;
                mask = 4'b0100;
            end
            DEST_Y3: begin
                s0   = S0_HIGH_BRANCH;
                s2   = LEAF_ODD;
                mask = 4'b1000;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: routes one word at a time through a shared 1-to-4 demux
// with a select settle window, valid/ready handoff and a stall timeout.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_dest (source side),
//        out_ready/out_valid/out_data (destinations), dmx_d/dmx_s0..s2
//        (demux control), drop_err (timeout pulse), busy.
module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int W          = 8,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_dest,
    input  logic [3:0]   out_ready,
    output logic [3:0]   out_valid,
    output logic [W-1:0] out_data,
    output logic         dmx_d,
    output logic         dmx_s0,
    output logic         dmx_s1,
    output logic         dmx_s2,
    output logic         drop_err,
    output logic         busy
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [7:0] tmo_cnt;
    logic [3:0] mask_q;

    logic       dec_s0;
    logic       dec_s1;
    logic       dec_s2;
    logic [3:0] dec_mask;
    logic       hit;

    route_sel_decode u_dec (
        .dest    (in_dest),
        .s1_prev (dmx_s1),
        .s2_prev (dmx_s2),
        .s0      (dec_s0),
        .s1      (dec_s1),
        .s2      (dec_s2),
        .mask    (dec_mask)
    );

    // Only the latched destination's ready counts
    assign hit      = |(out_ready & mask_q);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            mask_q     <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            dmx_d      <= 1'b0;
            dmx_s0     <= 1'b0;
            dmx_s1     <= 1'b0;
            dmx_s2     <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            drop_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data   <= in_data;
                        mask_q     <= dec_mask;
                        dmx_s0     <= dec_s0;
                        dmx_s1     <= dec_s1;
                        dmx_s2     <= dec_s2;
                        settle_cnt <= SETTLE_LD;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (settle_cnt == 4'd0) begin
                        dmx_d     <= 1'b1;
                        out_valid <= mask_q;
                        tmo_cnt   <= '0;
                        state     <= XFER;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                XFER: begin
                    // Ready wins over a simultaneous timeout
                    if (hit) begin
                        dmx_d     <= 1'b0;
                        out_valid <= '0;
                        state     <= RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        dmx_d     <= 1'b0;
                        out_valid <= '0;
                        drop_err  <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb_demux_route_ctrl: directed self-checking bench for demux_route_ctrl,
// default parameters plus a SETTLE_CYC=1 / TIMEOUT=2 instance.
module tb_demux_route_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_dest;
    logic [3:0]   out_ready;
    logic [3:0]   out_valid;
    logic [W-1:0] out_data;
    logic         dmx_d;
    logic         dmx_s0;
    logic         dmx_s1;
    logic         dmx_s2;
    logic         drop_err;
    logic         busy;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [W-1:0] b_in_data;
    logic [1:0]   b_in_dest;
    logic [3:0]   b_out_ready;
    logic [3:0]   b_out_valid;
    logic [W-1:0] b_out_data;
    logic         b_dmx_d;
    logic         b_dmx_s0;
    logic         b_dmx_s1;
    logic         b_dmx_s2;
    logic         b_drop_err;
    logic         b_busy;

    int passed = 0;
    int total  = 0;

    demux_route_ctrl #(.W(W), .SETTLE_CYC(2), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .dmx_d     (dmx_d),
        .dmx_s0    (dmx_s0),
        .dmx_s1    (dmx_s1),
        .dmx_s2    (dmx_s2),
        .drop_err  (drop_err),
        .busy      (busy)
    );

    demux_route_ctrl #(.W(W), .SETTLE_CYC(1), .TIMEOUT(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_dest   (b_in_dest),
        .out_ready (b_out_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .dmx_d     (b_dmx_d),
        .dmx_s0    (b_dmx_s0),
        .dmx_s1    (b_dmx_s1),
        .dmx_s2    (b_dmx_s2),
        .drop_err  (b_drop_err),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic route(input logic [1:0] d, input logic [W-1:0] data,
                         input logic [3:0] rdy, output int pulses,
                         output logic [3:0] seen, output int drops);
        pulses    = 0;
        seen      = 4'b0000;
        drops     = 0;
        in_valid  = 1'b1;
        in_dest   = d;
        in_data   = data;
        out_ready = rdy;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            if (out_valid != 4'b0000) pulses++;
            seen = seen | out_valid;
            if (drop_err) drops++;
            step();
        end
        out_ready = 4'b0000;
    endtask

    // Selects must not move while the demux data input is enabled
    logic [2:0] sel_hold = 3'b000;
    always @(negedge clk) begin
        if (rst_n && dmx_d) begin
            total++;
            assert ({dmx_s0, dmx_s1, dmx_s2} === sel_hold) passed++;
            else $error("FAIL sel_stable observed=%0h expected=%0h",
                        {dmx_s0, dmx_s1, dmx_s2}, sel_hold);
        end else begin
            sel_hold = {dmx_s0, dmx_s1, dmx_s2};
        end
    end

    int         np;
    int         nd;
    logic [3:0] sn;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_dest     = 2'd0;
        out_ready   = 4'b0000;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_dest   = 2'd0;
        b_out_ready = 4'b0000;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dmx_d", dmx_d, 0);
        chk("rst_sels", {dmx_s0, dmx_s1, dmx_s2}, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Latency walk: dest 2, ready held
        in_valid  = 1'b1;
        in_dest   = 2'd2;
        in_data   = 8'hA5;
        out_ready = 4'b0100;
        step();
        in_valid = 1'b0;
        chk("c1_sels", {dmx_s0, dmx_s1, dmx_s2}, 3'b100);
        chk("c1_dmx_d", dmx_d, 0);
        chk("c1_in_ready", in_ready, 0);
        chk("c1_busy", busy, 1);
        step();
        chk("c2_dmx_d", dmx_d, 0);
        chk("c2_out_valid", out_valid, 0);
        step();
        chk("c3_out_valid", out_valid, 4'b0100);
        chk("c3_out_data", out_data, 8'hA5);
        chk("c3_dmx_d", dmx_d, 1);
        step();
        chk("c4_out_valid", out_valid, 0);
        chk("c4_dmx_d", dmx_d, 0);
        chk("c4_in_ready", in_ready, 0);
        chk("c4_busy", busy, 1);
        step();
        chk("c5_in_ready", in_ready, 1);
        chk("c5_busy", busy, 0);
        out_ready = 4'b0000;

        // One word per destination, unused select retained
        route(2'd0, 8'h11, 4'b1111, np, sn, nd);
        chk("d0_pulses", np, 1);
        chk("d0_seen", sn, 4'b0001);
        chk("d0_drops", nd, 0);
        chk("d0_data", out_data, 8'h11);
        chk("d0_sels", {dmx_s0, dmx_s1, dmx_s2}, 3'b000);
        route(2'd1, 8'h22, 4'b1111, np, sn, nd);
        chk("d1_pulses", np, 1);
        chk("d1_seen", sn, 4'b0010);
        chk("d1_data", out_data, 8'h22);
        chk("d1_sels", {dmx_s0, dmx_s1, dmx_s2}, 3'b010);
        route(2'd2, 8'h33, 4'b1111, np, sn, nd);
        chk("d2_pulses", np, 1);
        chk("d2_seen", sn, 4'b0100);
        chk("d2_sels", {dmx_s0, dmx_s1, dmx_s2}, 3'b110);
        route(2'd3, 8'h44, 4'b1111, np, sn, nd);
        chk("d3_pulses", np, 1);
        chk("d3_seen", sn, 4'b1000);
        chk("d3_data", out_data, 8'h44);
        chk("d3_sels", {dmx_s0, dmx_s1, dmx_s2}, 3'b111);

        // Dest 1 never ready: 16 XFER cycles then one drop
        route(2'd1, 8'h5C, 4'b1101, np, sn, nd);
        chk("to_idle", in_ready, 1);
        chk("to_cycles", np, 16);
        chk("to_seen", sn, 4'b0010);
        chk("to_drops", nd, 1);
        chk("to_valid_off", out_valid, 0);
        chk("to_drop_now", drop_err, 0);

        // Ready arrives on the timeout limit cycle
        in_valid  = 1'b1;
        in_dest   = 2'd3;
        in_data   = 8'h9E;
        out_ready = 4'b0000;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("lim_first", out_valid, 4'b1000);
        for (int i = 0; i < 15; i++) step();
        chk("lim_last", out_valid, 4'b1000);
        chk("lim_last_drop", drop_err, 0);
        out_ready = 4'b1000;
        step();
        chk("lim_rel_drop", drop_err, 0);
        chk("lim_rel_valid", out_valid, 0);
        chk("lim_rel_dmx", dmx_d, 0);
        out_ready = 4'b0000;
        step();
        chk("lim_idle", in_ready, 1);
        chk("lim_idle_drop", drop_err, 0);

        // Async reset in the middle of XFER
        in_valid = 1'b1;
        in_dest  = 2'd0;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("ar_xfer", out_valid, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_dmx_d", dmx_d, 0);
        chk("ar_data", out_data, 0);
        chk("ar_sels", {dmx_s0, dmx_s1, dmx_s2}, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_busy", busy, 0);
        chk("ar_drop", drop_err, 0);
        step();
        rst_n = 1'b1;
        step();
        route(2'd2, 8'h5A, 4'b1111, np, sn, nd);
        chk("ar_rt_pulses", np, 1);
        chk("ar_rt_seen", sn, 4'b0100);
        chk("ar_rt_drops", nd, 0);
        chk("ar_rt_data", out_data, 8'h5A);

        // Short-parameter instance: settle 1, timeout 2
        b_in_valid  = 1'b1;
        b_in_dest   = 2'd1;
        b_in_data   = 8'h3C;
        b_out_ready = 4'b0010;
        step();
        b_in_valid = 1'b0;
        chk("b1_valid", b_out_valid, 0);
        chk("b1_dmx_d", b_dmx_d, 0);
        chk("b1_sels", {b_dmx_s0, b_dmx_s1, b_dmx_s2}, 3'b010);
        step();
        chk("b2_valid", b_out_valid, 4'b0010);
        chk("b2_data", b_out_data, 8'h3C);
        chk("b2_dmx_d", b_dmx_d, 1);
        step();
        chk("b3_valid", b_out_valid, 0);
        b_out_ready = 4'b0000;
        step();
        chk("b4_in_ready", b_in_ready, 1);

        b_in_valid = 1'b1;
        b_in_dest  = 2'd2;
        b_in_data  = 8'hC3;
        step();
        b_in_valid = 1'b0;
        step();
        chk("bt_x0_valid", b_out_valid, 4'b0100);
        step();
        chk("bt_x1_valid", b_out_valid, 4'b0100);
        chk("bt_x1_drop", b_drop_err, 0);
        step();
        chk("bt_rel_drop", b_drop_err, 1);
        chk("bt_rel_valid", b_out_valid, 0);
        step();
        chk("bt_idle_drop", b_drop_err, 0);
        chk("bt_idle_ready", b_in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
